// File: rtl/cp0_regs.sv
// cp0_regs: Coprocessor-0 Status/Cause/EPC, mfc0/mtc0 access, exception entry and eret.
// Define CP0_TIMER_EN to build the Count/Compare timer, which then owns Cause[15].
module cp0_regs #(
  parameter logic [31:0] EXC_VECTOR = 32'h0040_0004,
  parameter logic [31:0] STATUS_RST = 32'h0000_0000,
  parameter int          HW_INT_W   = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mfc0,
  input  logic                mtc0,
  input  logic [31:0]         pc,
  input  logic [4:0]          rd,
  input  logic [31:0]         wdata,
  input  logic                exception,
  input  logic                eret,
  input  logic [4:0]          cause,
  input  logic [HW_INT_W-1:0] hw_int,
  output logic [31:0]         rdata,
  output logic [31:0]         status,
  output logic [31:0]         exc_addr,
  output logic                irq_req
);

  localparam logic [4:0] RD_COUNT   = 5'd9;
  localparam logic [4:0] RD_COMPARE = 5'd11;
  localparam logic [4:0] RD_STATUS  = 5'd12;
  localparam logic [4:0] RD_CAUSE   = 5'd13;
  localparam logic [4:0] RD_EPC     = 5'd14;

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        irq_q, irq_d;
  logic        wr_en;
`ifdef CP0_TIMER_EN
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
`endif

  // mtc0 only lands when neither exception nor eret claims the cycle.
  assign wr_en = mtc0 & ~exception & ~eret;

  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    if (exception) begin
      epc_d        = pc;
      cause_d[6:2] = cause;
      status_d     = {status_q[26:0], 5'b0};
    end else if (eret) begin
      status_d = {5'b0, status_q[31:5]};
    end else if (wr_en) begin
      case (rd)
        RD_STATUS: status_d     = wdata;
        RD_CAUSE:  cause_d[9:8] = wdata[9:8];
        RD_EPC:    epc_d        = wdata;
        default:   ;
      endcase
    end
`ifdef CP0_TIMER_EN
    cause_d[14:10] = hw_int[4:0];
    // A Compare write clears the timer flag even if the match fires in the same cycle.
    if (wr_en && rd == RD_COMPARE) cause_d[15] = 1'b0;
    else if (count_q == compare_q) cause_d[15] = 1'b1;
    count_d   = (wr_en && rd == RD_COUNT)   ? wdata : count_q + 32'd1;
    compare_d = (wr_en && rd == RD_COMPARE) ? wdata : compare_q;
`else
    cause_d[15:10] = hw_int[5:0];
`endif
    irq_d = ~exception & status_q[0] & (|(cause_q[15:8] & status_q[15:8]));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status_q  <= STATUS_RST;
      cause_q   <= 32'h0;
      epc_q     <= 32'h0;
      irq_q     <= 1'b0;
`ifdef CP0_TIMER_EN
      count_q   <= 32'h0;
      compare_q <= 32'hFFFF_FFFF;
`endif
    end else begin
      status_q  <= status_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      irq_q     <= irq_d;
`ifdef CP0_TIMER_EN
      count_q   <= count_d;
      compare_q <= compare_d;
`endif
    end
  end

  // Reads see pre-edge values, so a same-cycle mtc0 is not forwarded.
  always_comb begin
    rdata = 32'h0;
    if (mfc0 && reset) begin
      case (rd)
        RD_STATUS:  rdata = status_q;
        RD_CAUSE:   rdata = cause_q;
        RD_EPC:     rdata = epc_q;
`ifdef CP0_TIMER_EN
        RD_COUNT:   rdata = count_q;
        RD_COMPARE: rdata = compare_q;
`endif
        default:    rdata = 32'h0;
      endcase
    end
  end

  assign status   = status_q;
  assign irq_req  = irq_q;
  assign exc_addr = eret ? epc_q : EXC_VECTOR;

endmodule

// File: tb/tb_cp0_regs.sv
// tb_cp0_regs: directed and random stimulus for cp0_regs, scored against a register-map model.
// Build with CP0_TIMER_EN defined to also exercise the Count/Compare timer.
module tb_cp0_regs;
  localparam logic [31:0] EXC_VECTOR = 32'h0040_0004;
  localparam logic [31:0] STATUS_RST = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        mfc0, mtc0, exception, eret;
  logic [31:0] pc, wdata;
  logic [4:0]  rd, cause;
  logic [5:0]  hw_int;
  logic [31:0] rdata, status, exc_addr;
  logic        irq_req;

  always #5 clk = ~clk;

  cp0_regs #(.EXC_VECTOR(EXC_VECTOR), .STATUS_RST(STATUS_RST), .HW_INT_W(6)) dut (
    .clk(clk), .reset(reset), .mfc0(mfc0), .mtc0(mtc0), .pc(pc), .rd(rd),
    .wdata(wdata), .exception(exception), .eret(eret), .cause(cause),
    .hw_int(hw_int), .rdata(rdata), .status(status), .exc_addr(exc_addr),
    .irq_req(irq_req)
  );

  int          n_cmp;
  int          n_bad;
  logic        running;
  logic [5:0]  hw_lvl;
  logic [31:0] exp_q[$];   // expected rdata, one entry per mfc0 cycle
  logic [64:0] obs_q[$];   // expected {status, exc_addr, irq_req}, one entry per cycle
  logic [64:0] mon_o;

  // Reference model: architectural register contents.
  logic [31:0] m_status, m_cause, m_epc;
  logic        m_irq;
`ifdef CP0_TIMER_EN
  logic [31:0] m_count, m_compare;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_status = STATUS_RST;
    m_cause  = 32'h0;
    m_epc    = 32'h0;
    m_irq    = 1'b0;
`ifdef CP0_TIMER_EN
    m_count   = 32'h0;
    m_compare = 32'hFFFF_FFFF;
`endif
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] r);
    case (r)
      5'd12: return m_status;
      5'd13: return m_cause;
      5'd14: return m_epc;
`ifdef CP0_TIMER_EN
      5'd9:  return m_count;
      5'd11: return m_compare;
`endif
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge of the architectural rules, using the inputs held this cycle.
  task automatic m_clock();
    logic [31:0] s, c, e;
    logic        accept, irq_n;
    s = m_status; c = m_cause; e = m_epc;
    accept = mtc0 && !exception && !eret;
    irq_n  = !exception && m_status[0] && ((m_cause[15:8] & m_status[15:8]) != 8'h0);
    if (exception) begin
      e = pc;
      c = (c & ~32'h0000_007C) | ({27'h0, cause} << 2);
      s = m_status << 5;
    end else if (eret) begin
      s = m_status >> 5;
    end else if (accept) begin
      if (rd == 5'd12) s = wdata;
      if (rd == 5'd13) c = (c & ~32'h0000_0300) | (wdata & 32'h0000_0300);
      if (rd == 5'd14) e = wdata;
    end
`ifdef CP0_TIMER_EN
    c = (c & ~32'h0000_7C00) | ({27'h0, hw_int[4:0]} << 10);
    if (accept && rd == 5'd11) c[15] = 1'b0;
    else if (m_count == m_compare) c[15] = 1'b1;
    m_count   = (accept && rd == 5'd9)  ? wdata : m_count + 32'd1;
    m_compare = (accept && rd == 5'd11) ? wdata : m_compare;
`else
    c = (c & ~32'h0000_FC00) | ({26'h0, hw_int} << 10);
`endif
    m_status = s; m_cause = c; m_epc = e; m_irq = irq_n;
  endtask

  // Driver: apply one cycle of inputs, queue the expected responses, advance the model.
  task automatic step(input logic rst_v, input logic mf, input logic mt, input logic ex,
                      input logic er, input logic [4:0] r, input logic [31:0] wd,
                      input logic [31:0] p, input logic [4:0] cs);
    reset = rst_v; mfc0 = mf; mtc0 = mt; exception = ex; eret = er;
    rd = r; wdata = wd; pc = p; cause = cs; hw_int = hw_lvl;
    if (!rst_v) m_reset();
    if (mf) exp_q.push_back(rst_v ? m_read(r) : 32'h0);
    obs_q.push_back({m_status, (er ? m_epc : EXC_VECTOR), m_irq});
    @(posedge clk);
    if (rst_v) m_clock();
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] wd);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, r, wd, 32'h0, 5'd0);
  endtask

  // Directed read against a fixed value, then the same read as a scored cycle.
  task automatic peek(input string nm, input logic [4:0] r, input logic [31:0] mask,
                      input logic [31:0] e);
    reset = 1'b1; mfc0 = 1'b1; mtc0 = 1'b0; exception = 1'b0; eret = 1'b0; rd = r;
    #1;
    chk(nm, rdata & mask, e);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, r, 32'h0, 32'h0, 5'd0);
  endtask

  // Monitor: check every driven cycle mid-period against the queued expectations.
  always @(negedge clk) begin
    if (running) begin
      if (obs_q.size() == 0) begin
        chk("obs_queue_empty", 32'h1, 32'h0);
      end else begin
        mon_o = obs_q.pop_front();
        chk("status", status, mon_o[64:33]);
        chk("exc_addr", exc_addr, mon_o[32:1]);
        chk("irq_req", {31'h0, irq_req}, {31'h0, mon_o[0]});
      end
      if (mfc0) begin
        if (exp_q.size() == 0) chk("rdata_queue_empty", 32'h1, 32'h0);
        else chk("rdata", rdata, exp_q.pop_front());
      end else begin
        chk("rdata_idle", rdata, 32'h0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] rd_tab [8];
    n_cmp = 0; n_bad = 0; running = 1'b0; hw_lvl = 6'h0;
    reset = 1'b0; mfc0 = 1'b0; mtc0 = 1'b0; exception = 1'b0; eret = 1'b0;
    rd = 5'd0; wdata = 32'h0; pc = 32'h0; cause = 5'd0; hw_int = 6'h0;
    rd_tab[0] = 5'd0;  rd_tab[1] = 5'd3;  rd_tab[2] = 5'd9;  rd_tab[3] = 5'd11;
    rd_tab[4] = 5'd12; rd_tab[5] = 5'd13; rd_tab[6] = 5'd14; rd_tab[7] = 5'd14;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    running = 1'b1;

    // Power-on reset state.
    mfc0 = 1'b1; rd = 5'd12; #1;
    chk("por_status", status, STATUS_RST);
    chk("por_irq", {31'h0, irq_req}, 32'h0);
    chk("por_exc_addr", exc_addr, EXC_VECTOR);
    chk("por_rdata", rdata, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd12, 32'h0, 32'h0, 5'd0);
    idle();

    // Exception then eret.
    wr(5'd12, 32'h0000_FF01);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0040_0100, 5'd8);
    #1;
    chk("exc_status", status, 32'h001F_E020);
    chk("exc_irq_forced", {31'h0, irq_req}, 32'h0);
    peek("exc_epc", 5'd14, 32'hFFFF_FFFF, 32'h0040_0100);
    peek("exc_cause", 5'd13, 32'h0000_007C, 32'h0000_0020);
    mfc0 = 1'b0; mtc0 = 1'b0; exception = 1'b0; eret = 1'b1; #1;
    chk("eret_exc_addr", exc_addr, 32'h0040_0100);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 32'h0, 5'd0);
    #1;
    chk("eret_status", status, 32'h0000_FF01);

    // Exception, eret and mtc0 EPC in one cycle: exception wins.
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd14, 32'h1234_5678, 32'h0040_0200, 5'd3);
    #1;
    chk("coll_status", status, 32'h001F_E020);
    peek("coll_epc", 5'd14, 32'hFFFF_FFFF, 32'h0040_0200);

    // Interrupt path: two edges from hw_int to irq_req, both directions.
    wr(5'd12, 32'h0000_0401);
    hw_lvl = 6'b000001;
    idle(); #1; chk("irq_edge1", {31'h0, irq_req}, 32'h0);
    idle(); #1; chk("irq_edge2", {31'h0, irq_req}, 32'h1);
    hw_lvl = 6'b000000;
    idle(); #1; chk("irq_drop_edge1", {31'h0, irq_req}, 32'h1);
    idle(); #1; chk("irq_drop_edge2", {31'h0, irq_req}, 32'h0);

`ifdef CP0_TIMER_EN
    // Count wraps and matches Compare; a Compare write clears the flag.
    wr(5'd9, 32'hFFFF_FFFE);
    wr(5'd11, 32'h0000_0001);
    idle(); idle();
    peek("timer_before", 5'd13, 32'h0000_8000, 32'h0);
    peek("timer_match", 5'd13, 32'h0000_8000, 32'h0000_8000);
    wr(5'd11, 32'h0000_0400);
    peek("timer_clear", 5'd13, 32'h0000_8000, 32'h0);
`else
    wr(5'd9, 32'h0000_AAAA);
    wr(5'd11, 32'h0000_5555);
    peek("no_count", 5'd9, 32'hFFFF_FFFF, 32'h0);
    peek("no_compare", 5'd11, 32'hFFFF_FFFF, 32'h0);
    hw_lvl = 6'b100000;
    idle();
    peek("hw5_ip7", 5'd13, 32'h0000_8000, 32'h0000_8000);
    hw_lvl = 6'b000000;
`endif

    // Unmapped register.
    wr(5'd3, 32'hDEAD_BEEF);
    peek("unmapped_rd", 5'd3, 32'hFFFF_FFFF, 32'h0);
    chk("unmapped_status", status, 32'h0000_0401);
    peek("unmapped_epc", 5'd14, 32'hFFFF_FFFF, 32'h0040_0200);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic rst_v, mf, mt, ex, er;
      logic [4:0] r;
      logic [31:0] wd;
      if ($urandom_range(0, 7) == 0) hw_lvl = 6'($urandom);
      rst_v = ($urandom_range(0, 299) != 0);
      mf = $urandom_range(0, 1) == 1;
      mt = $urandom_range(0, 2) == 0;
      ex = $urandom_range(0, 15) == 0;
      er = $urandom_range(0, 15) == 0;
      r  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : rd_tab[$urandom_range(0, 7)];
      wd = ($urandom_range(0, 1) == 1) ? $urandom : (32'h0000_FF01 & $urandom);
      step(rst_v, mf, mt, ex, er, r, wd, $urandom, 5'($urandom));
    end

    // Reset mid-operation with an interrupt pending.
    wr(5'd12, 32'h0000_FF01);
    wr(5'd14, 32'h0BAD_F00D);
    hw_lvl = 6'h3F;
    idle(); idle();
    #1; chk("pre_reset_irq", {31'h0, irq_req}, 32'h1);
    reset = 1'b0; mfc0 = 1'b1; rd = 5'd12; mtc0 = 1'b0; exception = 1'b0; eret = 1'b0;
    #1;
    chk("rst_status", status, STATUS_RST);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_irq", {31'h0, irq_req}, 32'h0);
    chk("rst_exc_addr", exc_addr, EXC_VECTOR);
    hw_lvl = 6'h0;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd12, 32'h0, 32'h0, 5'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0);
    peek("post_reset_epc", 5'd14, 32'hFFFF_FFFF, 32'h0);
    idle();

    running = 1'b0;
    @(negedge clk);
    chk("leftover_obs", obs_q.size(), 32'h0);
    chk("leftover_rdata", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
